// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and default widths for the L1-to-memory port arbiter.
package cache_arb_pkg;

   localparam int LINE_W_DEF = 256;
   localparam int ADDR_W_DEF = 32;
   localparam int CNT_W_DEF  = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } req_id_t;

   function automatic logic is_serving(arb_state_t s);
      return (s == SERVE_I) || (s == SERVE_D);
   endfunction

endpackage

// File: rtl/cache_mem_arbiter_rr2.sv
// Two-way round-robin picker; last_grant only moves when a served
// transaction completes, so a tie goes to whoever was not served last.
module arb_rr2
   import cache_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   input  req_id_t    served,
   output req_id_t    grant
);

   req_id_t last_grant_q;
   req_id_t last_grant_d;

   always_comb begin
      last_grant_d = last_grant_q;
      if (advance) begin
         last_grant_d = served;
      end
   end

   // Reset to D so the icache wins the very first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= REQ_D;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      grant = REQ_I;
      case (req)
         2'b10:   grant = REQ_D;
         2'b11:   grant = (last_grant_q == REQ_I) ? REQ_D : REQ_I;
         default: grant = REQ_I;
      endcase
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one cacheline-wide memory port between the L1 icache and dcache,
// driving it from latched request copies and steering the response back.
module cache_mem_arbiter
   import cache_arb_pkg::*;
#(
   parameter int LINE_W = LINE_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_addr,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp,
   output logic [CNT_W-1:0]  i_grant_cnt,
   output logic [CNT_W-1:0]  d_grant_cnt,
   output logic [CNT_W-1:0]  conflict_cnt
);

   arb_state_t state_q, state_d;
   req_id_t    grant;
   req_id_t    served;
   logic       d_req;
   logic       any_req;
   logic       done;

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic              write_q, write_d;
   logic [CNT_W-1:0]  i_cnt_q, i_cnt_d;
   logic [CNT_W-1:0]  d_cnt_q, d_cnt_d;
   logic [CNT_W-1:0]  conf_cnt_q, conf_cnt_d;

   assign d_req   = d_read | d_write;
   assign any_req = i_read | d_req;
   assign done    = is_serving(state_q) & pmem_resp;
   assign served  = (state_q == SERVE_D) ? REQ_D : REQ_I;

   arb_rr2 u_rr (
      .clk     (clk),
      .rst     (rst),
      .req     ({d_req, i_read}),
      .advance (done),
      .served  (served),
      .grant   (grant)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = (grant == REQ_I) ? SERVE_I : SERVE_D;
         SERVE_I: if (pmem_resp) state_d = RELEASE;
         SERVE_D: if (pmem_resp) state_d = RELEASE;
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Requests are captured only on the grant edge; a read+write clash counts as a write.
   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      write_d = write_q;
      if ((state_q == IDLE) && any_req) begin
         if (grant == REQ_I) begin
            addr_d  = i_addr;
            wdata_d = '0;
            write_d = 1'b0;
         end else begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            write_d = d_write;
         end
      end
   end

   always_comb begin
      i_cnt_d    = i_cnt_q;
      d_cnt_d    = d_cnt_q;
      conf_cnt_d = conf_cnt_q;
      if ((state_q == IDLE) && i_read && d_req) conf_cnt_d = conf_cnt_q + CNT_W'(1);
      if (done && (served == REQ_I)) i_cnt_d = i_cnt_q + CNT_W'(1);
      if (done && (served == REQ_D)) d_cnt_d = d_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         write_q    <= 1'b0;
         i_cnt_q    <= '0;
         d_cnt_q    <= '0;
         conf_cnt_q <= '0;
      end else begin
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         write_q    <= write_d;
         i_cnt_q    <= i_cnt_d;
         d_cnt_q    <= d_cnt_d;
         conf_cnt_q <= conf_cnt_d;
      end
   end

   // Strobes drop in the response cycle itself so memory never sees a second request.
   always_comb begin
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      pmem_addr  = '0;
      pmem_wdata = '0;
      i_resp     = 1'b0;
      d_resp     = 1'b0;
      i_rdata    = '0;
      d_rdata    = '0;
      case (state_q)
         SERVE_I: begin
            pmem_read = ~pmem_resp;
            pmem_addr = addr_q;
            i_resp    = pmem_resp;
            i_rdata   = pmem_rdata;
         end
         SERVE_D: begin
            pmem_read  = ~write_q & ~pmem_resp;
            pmem_write = write_q & ~pmem_resp;
            pmem_addr  = addr_q;
            pmem_wdata = write_q ? wdata_q : '0;
            d_resp     = pmem_resp;
            d_rdata    = pmem_rdata;
         end
         default: begin
         end
      endcase
   end

   assign i_grant_cnt  = i_cnt_q;
   assign d_grant_cnt  = d_cnt_q;
   assign conflict_cnt = conf_cnt_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for writeback, round-robin fairness and reset.
module tb_cache_mem_arbiter;

   localparam int LINE_W = 256;
   localparam int ADDR_W = 32;
   localparam int CNT_W  = 32;
   localparam logic [ADDR_W-1:0] I_ADDR = 32'h0000_1000;
   localparam logic [ADDR_W-1:0] D_ADDR = 32'h8000_0040;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_read, d_read, d_write, pmem_resp;
   logic [ADDR_W-1:0] i_addr, d_addr;
   logic [LINE_W-1:0] d_wdata, pmem_rdata;
   logic [LINE_W-1:0] i_rdata, d_rdata, pmem_wdata;
   logic              i_resp, d_resp, pmem_read, pmem_write;
   logic [ADDR_W-1:0] pmem_addr;
   logic [CNT_W-1:0]  i_grant_cnt, d_grant_cnt, conflict_cnt;

   logic [LINE_W-1:0] rdata_pat;
   logic [LINE_W-1:0] wdata_pat;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic              i_read;
      logic              d_read;
      logic              d_write;
      logic              resp;
      logic [ADDR_W-1:0] i_addr;
      logic              exp_rd;
      logic              exp_wr;
      logic              chk_addr;
      logic [ADDR_W-1:0] exp_addr;
      logic              exp_iresp;
      logic              exp_dresp;
   } vec_t;

   vec_t vecs[22];

   cache_mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_read       (i_read),
      .i_addr       (i_addr),
      .i_rdata      (i_rdata),
      .i_resp       (i_resp),
      .d_read       (d_read),
      .d_write      (d_write),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_rdata      (d_rdata),
      .d_resp       (d_resp),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_addr    (pmem_addr),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp),
      .i_grant_cnt  (i_grant_cnt),
      .d_grant_cnt  (d_grant_cnt),
      .conflict_cnt (conflict_cnt)
   );

   always #5 clk = ~clk;

   // The dcache must never ask for a read and a writeback at once.
   always @(negedge clk) begin
      if (!rst) assert (!(d_read && d_write)) else $error("[TB] d_read and d_write both high");
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] simulation hung");
   end

   function automatic vec_t mk(logic ir, logic dr, logic dw, logic rs, logic [ADDR_W-1:0] ia,
                               logic erd, logic ewr, logic ca, logic [ADDR_W-1:0] ea,
                               logic eir, logic edr);
      vec_t v;
      v.i_read = ir; v.d_read = dr; v.d_write = dw; v.resp = rs; v.i_addr = ia;
      v.exp_rd = erd; v.exp_wr = ewr; v.chk_addr = ca; v.exp_addr = ea;
      v.exp_iresp = eir; v.exp_dresp = edr;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      @(posedge clk);
      #1;
      i_read    = v.i_read;
      d_read    = v.d_read;
      d_write   = v.d_write;
      pmem_resp = v.resp;
      i_addr    = v.i_addr;
   endtask

   task automatic idleInputs();
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
      i_addr = I_ADDR; d_addr = D_ADDR; d_wdata = '0;
   endtask

   task automatic doReset();
      idleInputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      rdata_pat = {8{32'hDEAD_BEEF}};
      wdata_pat = {32{8'hA5}};
      pmem_rdata = rdata_pat;

      //           ir dr dw rs i_addr        rd wr ca addr    ir dr
      vecs[0]  = mk(1, 0, 0, 0, I_ADDR,        0, 0, 0, '0,     0, 0);
      vecs[1]  = mk(1, 0, 0, 0, I_ADDR,        1, 0, 1, I_ADDR, 0, 0);
      vecs[2]  = mk(1, 0, 0, 0, 32'h0000_2000, 1, 0, 1, I_ADDR, 0, 0);
      vecs[3]  = mk(1, 0, 0, 0, I_ADDR,        1, 0, 1, I_ADDR, 0, 0);
      vecs[4]  = mk(1, 0, 0, 0, I_ADDR,        1, 0, 1, I_ADDR, 0, 0);
      vecs[5]  = mk(1, 0, 0, 1, I_ADDR,        0, 0, 1, I_ADDR, 1, 0);
      vecs[6]  = mk(0, 0, 0, 0, I_ADDR,        0, 0, 0, '0,     0, 0);
      vecs[7]  = mk(0, 0, 0, 0, I_ADDR,        0, 0, 0, '0,     0, 0);
      vecs[8]  = mk(0, 0, 1, 0, I_ADDR,        0, 0, 0, '0,     0, 0);
      vecs[9]  = mk(0, 0, 1, 0, I_ADDR,        0, 1, 1, D_ADDR, 0, 0);
      vecs[10] = mk(0, 0, 0, 0, I_ADDR,        0, 1, 1, D_ADDR, 0, 0);
      vecs[11] = mk(0, 0, 0, 1, I_ADDR,        0, 0, 1, D_ADDR, 0, 1);
      vecs[12] = mk(0, 0, 0, 0, I_ADDR,        0, 0, 0, '0,     0, 0);
      vecs[13] = mk(1, 1, 0, 0, I_ADDR,        0, 0, 0, '0,     0, 0);
      vecs[14] = mk(1, 1, 0, 0, I_ADDR,        1, 0, 1, I_ADDR, 0, 0);
      vecs[15] = mk(1, 1, 0, 1, I_ADDR,        0, 0, 1, I_ADDR, 1, 0);
      vecs[16] = mk(0, 1, 0, 0, I_ADDR,        0, 0, 0, '0,     0, 0);
      vecs[17] = mk(0, 1, 0, 0, I_ADDR,        0, 0, 0, '0,     0, 0);
      vecs[18] = mk(0, 1, 0, 1, I_ADDR,        0, 0, 1, D_ADDR, 0, 1);
      vecs[19] = mk(0, 0, 0, 0, I_ADDR,        0, 0, 0, '0,     0, 0);
      vecs[20] = mk(0, 0, 0, 1, I_ADDR,        0, 0, 0, '0,     0, 0);
      vecs[21] = mk(0, 0, 0, 0, I_ADDR,        0, 0, 0, '0,     0, 0);

      doReset();
      #1;
      checkOutput("reset pmem_read", pmem_read, 0);
      checkOutput("reset pmem_write", pmem_write, 0);
      checkOutput("reset pmem_addr", pmem_addr, 0);
      checkOutput("reset pmem_wdata", pmem_wdata, 0);
      checkOutput("reset i_resp", i_resp, 0);
      checkOutput("reset d_resp", d_resp, 0);
      checkOutput("reset i_grant_cnt", i_grant_cnt, 0);
      checkOutput("reset d_grant_cnt", d_grant_cnt, 0);
      checkOutput("reset conflict_cnt", conflict_cnt, 0);

      for (int i = 0; i < 22; i++) begin
         applyStimulus(vecs[i]);
         #3;
         checkOutput($sformatf("v%0d pmem_read", i), pmem_read, vecs[i].exp_rd);
         checkOutput($sformatf("v%0d pmem_write", i), pmem_write, vecs[i].exp_wr);
         checkOutput($sformatf("v%0d i_resp", i), i_resp, vecs[i].exp_iresp);
         checkOutput($sformatf("v%0d d_resp", i), d_resp, vecs[i].exp_dresp);
         if (vecs[i].chk_addr) checkOutput($sformatf("v%0d pmem_addr", i), pmem_addr, vecs[i].exp_addr);
      end
      @(posedge clk);
      #1;
      checkOutput("table i_grant_cnt", i_grant_cnt, 2);
      checkOutput("table d_grant_cnt", d_grant_cnt, 2);
      checkOutput("table conflict_cnt", conflict_cnt, 1);

      // Writeback: wdata must stay on the latched value even when the dcache changes it.
      doReset();
      @(posedge clk);
      #1 d_write = 1'b1; d_wdata = wdata_pat;
      @(posedge clk);
      #1 d_write = 1'b0; d_wdata = ~wdata_pat;
      for (int k = 0; k < 3; k++) begin
         #1;
         checkOutput($sformatf("wb%0d pmem_write", k), pmem_write, 1);
         checkOutput($sformatf("wb%0d pmem_read", k), pmem_read, 0);
         checkOutput($sformatf("wb%0d pmem_wdata", k), pmem_wdata, wdata_pat);
         checkOutput($sformatf("wb%0d pmem_addr", k), pmem_addr, D_ADDR);
         @(posedge clk);
         #1;
      end
      pmem_resp = 1'b1;
      #1;
      checkOutput("wb resp d_resp", d_resp, 1);
      checkOutput("wb resp i_resp", i_resp, 0);
      checkOutput("wb resp pmem_write", pmem_write, 0);
      @(posedge clk);
      #1 pmem_resp = 1'b0;
      checkOutput("wb d_grant_cnt", d_grant_cnt, 1);

      // Both sides request forever: grants must alternate starting with the icache.
      doReset();
      i_read = 1'b1; d_read = 1'b1;
      for (int t = 0; t < 10; t++) begin
         logic got;
         logic want_d;
         want_d = (t % 2) == 1;
         got = 1'b0;
         for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #2;
            if (pmem_read) begin
               got = 1'b1;
               break;
            end
         end
         if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL rr%0d no strobe got 0 want 1", t);
         end else begin
            checkOutput($sformatf("rr%0d pmem_addr", t), pmem_addr, want_d ? D_ADDR : I_ADDR);
            pmem_resp = 1'b1;
            #1;
            checkOutput($sformatf("rr%0d i_resp", t), i_resp, !want_d);
            checkOutput($sformatf("rr%0d d_resp", t), d_resp, want_d);
            checkOutput($sformatf("rr%0d i_rdata", t), i_rdata, want_d ? '0 : rdata_pat);
            checkOutput($sformatf("rr%0d d_rdata", t), d_rdata, want_d ? rdata_pat : '0);
            @(posedge clk);
            #1 pmem_resp = 1'b0;
         end
      end
      i_read = 1'b0; d_read = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rr i_grant_cnt", i_grant_cnt, 5);
      checkOutput("rr d_grant_cnt", d_grant_cnt, 5);
      checkOutput("rr conflict_cnt", conflict_cnt, 10);

      // Reset in the middle of a dcache read, then a stray late response.
      doReset();
      @(posedge clk);
      #1 d_read = 1'b1;
      @(posedge clk);
      #2;
      checkOutput("rst serving pmem_read", pmem_read, 1);
      rst = 1'b1; d_read = 1'b0;
      @(posedge clk);
      #2;
      checkOutput("rst after pmem_read", pmem_read, 0);
      checkOutput("rst after pmem_write", pmem_write, 0);
      rst = 1'b0;
      pmem_resp = 1'b1;
      #1;
      checkOutput("stray d_resp", d_resp, 0);
      checkOutput("stray i_resp", i_resp, 0);
      @(posedge clk);
      #1 pmem_resp = 1'b0;
      checkOutput("stray d_grant_cnt", d_grant_cnt, 0);
      checkOutput("stray i_grant_cnt", i_grant_cnt, 0);
      checkOutput("stray pmem_read", pmem_read, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory port (cacheline-wide, burst handled downstream) between the L1 instruction cache and the L1 data cache.
- Accepts one outstanding request per requester and grants round-robin when both contend.
- Drives the pmem port from registered copies of the granted request, and routes pmem_resp/rdata back to the winner only.
- Sits between the two L1 cache controllers and the cacheline adaptor/L2.

Parameters:
- LINE_W, 256, cacheline width in bits
- ADDR_W, 32, physical address width
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- i_read  in  1  icache line-fill request
- i_addr  in  ADDR_W  icache line address
- i_rdata  out  LINE_W  line data to icache
- i_resp  out  1  icache request complete
- d_read  in  1  dcache line-fill request
- d_write  in  1  dcache writeback request
- d_addr  in  ADDR_W  dcache line address
- d_wdata  in  LINE_W  dcache writeback data
- d_rdata  out  LINE_W  line data to dcache
- d_resp  out  1  dcache request complete
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_addr  out  ADDR_W  memory address
- pmem_wdata  out  LINE_W  memory write data
- pmem_rdata  in  LINE_W  memory read data
- pmem_resp  in  1  memory transaction complete
- i_grant_cnt  out  CNT_W  icache transactions completed
- d_grant_cnt  out  CNT_W  dcache transactions completed
- conflict_cnt  out  CNT_W  cycles in IDLE with both requesting

Behaviour:
- States: IDLE, SERVE_I, SERVE_D, RELEASE. Reset value: state = IDLE, last_grant = D (so icache wins the first tie).
- Reset values of outputs: all pmem strobes/addr/wdata = 0, i_resp = d_resp = 0, counters = 0.
- d_req = d_read | d_write. d_read and d_write both high is illegal; the bench asserts against it, and the RTL treats it as a write.
- IDLE:
  - Only i_read: go to SERVE_I.
  - Only d_req: go to SERVE_D.
  - Both: grant the requester not equal to last_grant, and increment conflict_cnt.
  - On the grant edge, latch into request registers: addr (and wdata/op for D).
- SERVE_I/SERVE_D:
  - pmem_read/pmem_write/pmem_addr/pmem_wdata come from the latched registers only, held stable until pmem_resp.
  - Earliest strobe is the cycle after the request is first seen in IDLE (1-cycle grant latency).
  - Requester inputs are ignored while serving.
- Completion:
  - Cycle with pmem_resp=1: the granted resp (i_resp or d_resp) = pmem_resp, combinational, same cycle.
  - The granted rdata = pmem_rdata, passthrough.
  - The non-granted resp stays 0.
  - On that edge: set last_grant, increment the matching grant counter, go to RELEASE.
- RELEASE:
  - One bubble cycle; no strobes, no resp. Then go to IDLE.
  - Guarantees the served requester has dropped its request before re-arbitration, so no double service.
- Strobes deasserted in the pmem_resp cycle: pmem_read/write = state-based & ~pmem_resp.
- rdata outputs of the non-granted side = 0.
- A request arriving while the other is served waits; worst-case wait = one full transaction + RELEASE.
- Counters wrap modulo 2^CNT_W.
- rst mid-transaction: next cycle state = IDLE, strobes = 0, latched request discarded. A late pmem_resp while IDLE is ignored (no resp to either side).
- pmem_resp while IDLE/RELEASE: ignored, no counter change.

Decomposition:
- Package cache_arb_pkg: state enum arb_state_t {IDLE, SERVE_I, SERVE_D, RELEASE}; requester enum req_id_t {REQ_I, REQ_D}; default widths.
- One natural sub-module: arb_rr2, a 2-input round-robin picker with last_grant register (inputs req[1:0], advance; output grant id).
- Datapath muxing and counters stay in the top.

Test Plan:
- Lone icache: i_read=1, i_addr=0x0000_1000, pmem_resp after 5 cycles → pmem_read=1, pmem_addr=0x1000 from cycle+1; i_resp=1 exactly in resp cycle; i_grant_cnt=1; RELEASE then IDLE.
- Tie after reset: i_read and d_read both high in the same cycle → icache served first, conflict_cnt=1; dcache served next; grant order I,D; d_resp waits until I resp + 1 RELEASE cycle.
- Writeback: d_write=1, d_addr=0x8000_0040, d_wdata=pattern 0xA5.. → pmem_write=1 with the exact wdata held stable until resp; pmem_read=0 throughout; d_resp in resp cycle.
- Starvation check: icache requests continuously and dcache requests continuously for 10 transactions → grants alternate I,D,I,D…; counts 5/5.
- Reset mid-op: rst during SERVE_D before resp → strobes 0 next cycle; later stray pmem_resp produces no d_resp/i_resp; counters 0.
- Input change while serving: i_addr changes during SERVE_I → pmem_addr unchanged.
